// File: rtl/cnt_multichan_pkg.sv
// cnt_pkg: shared widths, types and the lowest-zero priority encoder for cnt_multichan.
package cnt_pkg;
  localparam int DEF_BITWIDTH = 8;
  localparam int DEF_NUM_CH = 4;
  localparam int LSZ_MAXW = 64;
  typedef logic [DEF_BITWIDTH-1:0] cnt_t;
  typedef logic [$clog2(DEF_BITWIDTH+1)-1:0] lsz_t;
  function automatic int lszw_f(input int w);
    return $clog2(w + 1);
  endfunction
  // Zero-extended input: an all-ones count of width W yields W.
  function automatic int unsigned lsz_f(input logic [LSZ_MAXW-1:0] v);
    int unsigned r;
    r = LSZ_MAXW;
    for (int i = LSZ_MAXW - 1; i >= 0; i--) if (!v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/cnt_multichan_if.sv
// cnt_multichan_if: control/data bundle for the counter bank; oLsz only with CNT_LSZ_EN.
interface cnt_multichan_if
  import cnt_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int NUM_CH = DEF_NUM_CH
);
  logic [NUM_CH-1:0] iEn;
  logic iClr;
  logic [NUM_CH-1:0] iLoad;
  logic [NUM_CH*BITWIDTH-1:0] iLoadVal;
  logic [NUM_CH-1:0] iDown;
  logic [NUM_CH*BITWIDTH-1:0] oCnt;
  logic [NUM_CH-1:0] oTc;
`ifdef CNT_LSZ_EN
  logic [NUM_CH*lszw_f(BITWIDTH)-1:0] oLsz;
  modport master(output iEn, iClr, iLoad, iLoadVal, iDown, input oCnt, oTc, oLsz);
  modport slave(input iEn, iClr, iLoad, iLoadVal, iDown, output oCnt, oTc, oLsz);
`else
  modport master(output iEn, iClr, iLoad, iLoadVal, iDown, input oCnt, oTc);
  modport slave(input iEn, iClr, iLoad, iLoadVal, iDown, output oCnt, oTc);
`endif
endinterface

// File: rtl/cnt_multichan_chan.sv
// cnt_chan: one counter channel with clear/load/enable priority, wrap or saturate, terminal-count
// pulse and, with CNT_LSZ_EN, a registered lowest-zero index.
module cnt_chan
  import cnt_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int SATURATE = 0,
  parameter int LSZW = lszw_f(BITWIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic                en_i,
  input  logic                down_i,
  input  logic [BITWIDTH-1:0] load_val_i,
  output logic [BITWIDTH-1:0] cnt_o,
`ifdef CNT_LSZ_EN
  output logic [LSZW-1:0]     lsz_o,
`endif
  output logic                tc_o
);
  logic [BITWIDTH-1:0] cnt_q, cnt_d, step;
  logic tc_q, tc_d, at_term;
  always_comb begin
    at_term = down_i ? (cnt_q == '0) : (&cnt_q);
    step = down_i ? cnt_q - 1'b1 : cnt_q + 1'b1;
    cnt_d = clr_i ? '0 : load_i ? load_val_i : !en_i ? cnt_q : (SATURATE != 0 && at_term) ? cnt_q : step;
    tc_d = !clr_i && !load_i && en_i && at_term;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q <= tc_d;
    end
  end
`ifdef CNT_LSZ_EN
  logic [LSZW-1:0] lsz_q;
  always_ff @(posedge clk) lsz_q <= !rst_n ? '0 : LSZW'(lsz_f(LSZ_MAXW'(cnt_d)));
  assign lsz_o = lsz_q;
`endif
  assign cnt_o = cnt_q;
  assign tc_o = tc_q;
endmodule

// File: rtl/cnt_multichan.sv
// cnt_multichan: NUM_CH independent counters behind one interface; define CNT_LSZ_EN for oLsz.
module cnt_multichan
  import cnt_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SATURATE = 0
) (
  input logic iClk,
  input logic iRstN,
  cnt_multichan_if.slave bus
);
  localparam int LSZW = lszw_f(BITWIDTH);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cnt_chan #(.BITWIDTH(BITWIDTH), .SATURATE(SATURATE), .LSZW(LSZW)) u_chan (
      .clk        (iClk),
      .rst_n      (iRstN),
      .clr_i      (bus.iClr),
      .load_i     (bus.iLoad[c]),
      .en_i       (bus.iEn[c]),
      .down_i     (bus.iDown[c]),
      .load_val_i (bus.iLoadVal[c*BITWIDTH +: BITWIDTH]),
      .cnt_o      (bus.oCnt[c*BITWIDTH +: BITWIDTH]),
`ifdef CNT_LSZ_EN
      .lsz_o      (bus.oLsz[c*LSZW +: LSZW]),
`endif
      .tc_o       (bus.oTc[c])
    );
  end
endmodule

// File: tb/tb_cnt_multichan.sv
// tb_cnt_multichan: wrap and saturate banks driven in parallel against an integer reference model.
module tb_cnt_multichan;
  localparam int W = 8;
  localparam int N = 4;
  localparam int LW = $clog2(W + 1);
  logic clk = 1'b0;
  logic rstn, clr;
  logic [N-1:0] en, load, down;
  logic [N*W-1:0] lval;
  int checks = 0;
  int errors = 0;
  int mc[2][N];
  bit mt[2][N];
  always #5 clk = ~clk;
  cnt_multichan_if #(.BITWIDTH(W), .NUM_CH(N)) bw ();
  cnt_multichan_if #(.BITWIDTH(W), .NUM_CH(N)) bs ();
  assign bw.iEn = en;
  assign bw.iClr = clr;
  assign bw.iLoad = load;
  assign bw.iLoadVal = lval;
  assign bw.iDown = down;
  assign bs.iEn = en;
  assign bs.iClr = clr;
  assign bs.iLoad = load;
  assign bs.iLoadVal = lval;
  assign bs.iDown = down;
  cnt_multichan #(.BITWIDTH(W), .NUM_CH(N), .SATURATE(0)) dut_w (.iClk(clk), .iRstN(rstn), .bus(bw.slave));
  cnt_multichan #(.BITWIDTH(W), .NUM_CH(N), .SATURATE(1)) dut_s (.iClk(clk), .iRstN(rstn), .bus(bs.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lsz_ref(input int v);
    int i = 0;
    while (i < W && v[i]) i++;
    return i;
  endfunction

  task automatic model_step();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < N; c++) begin
        int lim;
        bit term;
        lim = (1 << W) - 1;
        term = down[c] ? (mc[m][c] == 0) : (mc[m][c] == lim);
        if (!rstn || clr) begin
          mc[m][c] = 0;
          mt[m][c] = 0;
        end else if (load[c]) begin
          mc[m][c] = int'(lval[c*W +: W]);
          mt[m][c] = 0;
        end else if (en[c]) begin
          mt[m][c] = term;
          if (!(m == 1 && term)) mc[m][c] = (mc[m][c] + (down[c] ? lim : 1)) % (lim + 1);
        end else mt[m][c] = 0;
      end
  endtask

  task automatic tick();
    logic [N*W-1:0] oc;
    logic [N-1:0] ot;
    @(posedge clk);
    model_step();
    #1;
    for (int m = 0; m < 2; m++) begin
      oc = m ? bs.oCnt : bw.oCnt;
      ot = m ? bs.oTc : bw.oTc;
      for (int c = 0; c < N; c++) begin
        check($sformatf("cnt m%0d c%0d", m, c), 32'(oc[c*W +: W]), 32'(mc[m][c]));
        check($sformatf("tc m%0d c%0d", m, c), 32'(ot[c]), 32'(mt[m][c]));
`ifdef CNT_LSZ_EN
        begin
          logic [N*LW-1:0] ol;
          ol = m ? bs.oLsz : bw.oLsz;
          check($sformatf("lsz m%0d c%0d", m, c), 32'(ol[c*LW +: LW]), 32'(lsz_ref(mc[m][c])));
        end
`endif
      end
    end
  endtask

  initial begin
    logic [7:0] pick[5];
    rstn = 0; clr = 0; en = '1; load = '1; down = 0; lval = '0;
    en = '1; load = '1;
    en = 4'hF; load = 4'hF; lval = 32'hAABBCCDD;
    repeat (2) tick();
    check("rst cnt", bw.oCnt, 32'h0);
    check("rst tc", 32'(bw.oTc), 32'h0);
    rstn = 1; load = 0; en = 4'hF;
    repeat (3) tick();
    check("release", bw.oCnt, 32'h03030303);
    en = 0; load = 4'b0001; lval[7:0] = 8'hFE;
    tick();
    load = 0; en = 4'b0001;
    tick();
    check("wrap1", 32'(bw.oCnt[7:0]), 32'hFF);
    tick();
    check("wrap2", 32'(bw.oCnt[7:0]), 32'h00);
    check("wrap2 tc", 32'(bw.oTc[0]), 32'h1);
    tick();
    check("wrap3", 32'(bw.oCnt[7:0]), 32'h01);
    check("wrap3 tc", 32'(bw.oTc[0]), 32'h0);
    en = 0; load = 4'b0010; lval[15:8] = 8'h01;
    tick();
    load = 0; en = 4'b0010; down = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat cnt", 32'(bs.oCnt[15:8]), 32'h00);
      check("sat tc", 32'(bs.oTc[1]), i == 0 ? 32'h0 : 32'h1);
    end
    en = 0; down = 0; clr = 1; tick();
    check("clr", bw.oCnt, 32'h0);
    clr = 0; load = 4'b0100; en = 4'b0100; lval[23:16] = 8'h40;
    tick();
    check("load pri", 32'(bw.oCnt[23:16]), 32'h40);
    load = 4'b1001; en = 0; lval[7:0] = 8'h00; lval[31:24] = 8'h10;
    tick();
    load = 0; en = 4'b1001; down = 4'b1000;
    tick();
    check("dir dn", 32'(bw.oCnt[31:24]), 32'h0F);
    down = 0;
    tick();
    check("dir up", 32'(bw.oCnt[31:24]), 32'h10);
    check("ch0 indep", 32'(bw.oCnt[7:0]), 32'h02);
    en = 0;
    pick = '{8'h00, 8'h01, 8'h03, 8'h07, 8'hFF};
    for (int i = 0; i < 5; i++) begin
      load = 4'b0001; lval[7:0] = pick[i];
      tick();
`ifdef CNT_LSZ_EN
      check("lsz dir", 32'(bw.oLsz[LW-1:0]), i == 4 ? 32'd8 : 32'(i));
`endif
    end
    load = 0; en = 4'hF; rstn = 0;
    tick();
    rstn = 1;
    for (int i = 0; i < 600; i++) begin
      rstn = ($urandom % 60) != 0;
      clr = ($urandom % 25) == 0;
      load = 4'($urandom & $urandom & $urandom);
      en = 4'($urandom | $urandom);
      down = (i % 80 < 40) ? 4'($urandom & $urandom & $urandom) : 4'($urandom | $urandom | $urandom);
      for (int c = 0; c < N; c++) begin
        pick = '{8'h00, 8'hFF, 8'hFE, 8'h01, 8'($urandom)};
        lval[c*W +: W] = pick[$urandom % 5];
      end
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
